// File: rtl/risc_pkg.sv
// risc_pkg: constants shared by the RISC datapath (processing_unit) and the
// control unit that drives it.
//   word_size   datapath, register, address and bus width
//   Sel1_size   width of the Bus_1 mux select
//   Sel2_size   width of the Bus_2 mux select
//   alu_op_e    ALU opcodes carried in instruction[7:4]
//   SEL1_*      Bus_1 source codes (R0-R7, PC); all other codes drive 0
//   SEL2_*      Bus_2 source codes (ALU, Bus_1, memory, constant 0)
package risc_pkg;

    localparam int unsigned word_size = 8;
    localparam int unsigned Sel1_size = 4;
    localparam int unsigned Sel2_size = 2;
    localparam int unsigned op_size   = 4;

    // Constant 1 at datapath width, used for increment/decrement and compares.
    localparam logic [word_size-1:0] WORD_ONE = {{(word_size-1){1'b0}}, 1'b1};

    typedef enum logic [op_size-1:0] {
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0011,
        OP_INC  = 4'b0100,
        OP_DEC  = 4'b0101,
        OP_SLT  = 4'b1001,
        OP_SGT  = 4'b1010,
        OP_AND  = 4'b1011,
        OP_OR   = 4'b1101,
        OP_NAND = 4'b1111
    } alu_op_e;

    localparam logic [Sel1_size-1:0] SEL1_R0 = 4'd0;
    localparam logic [Sel1_size-1:0] SEL1_R1 = 4'd1;
    localparam logic [Sel1_size-1:0] SEL1_R2 = 4'd2;
    localparam logic [Sel1_size-1:0] SEL1_R3 = 4'd3;
    localparam logic [Sel1_size-1:0] SEL1_R4 = 4'd4;
    localparam logic [Sel1_size-1:0] SEL1_R5 = 4'd5;
    localparam logic [Sel1_size-1:0] SEL1_R6 = 4'd6;
    localparam logic [Sel1_size-1:0] SEL1_R7 = 4'd7;
    localparam logic [Sel1_size-1:0] SEL1_PC = 4'd8;

    localparam logic [Sel2_size-1:0] SEL2_ALU  = 2'd0;
    localparam logic [Sel2_size-1:0] SEL2_BUS1 = 2'd1;
    localparam logic [Sel2_size-1:0] SEL2_MEM  = 2'd2;
    localparam logic [Sel2_size-1:0] SEL2_ZERO = 2'd3;

    // Zero detect used for the Reg_Z update.
    function automatic logic is_zero(input logic [word_size-1:0] v);
        return (v == {word_size{1'b0}});
    endfunction

endpackage

// File: rtl/risc_alu.sv
// risc_alu: purely combinational ALU of the RISC datapath.
//   a   in  word_size  operand A (Reg_Y)
//   b   in  word_size  operand B (Bus_1)
//   op  in  op_size    opcode, instruction[7:4]
//   y   out word_size  result; arithmetic wraps, compares are unsigned,
//                      unlisted opcodes pass B through
module risc_alu
    import risc_pkg::*;
(
    input  logic [word_size-1:0] a,
    input  logic [word_size-1:0] b,
    input  logic [op_size-1:0]   op,
    output logic [word_size-1:0] y
);

    logic [word_size-1:0] y_s;

    // Opcode decode and result selection.
    always_comb begin
        y_s = b;
        case (alu_op_e'(op))
            OP_ADD:  y_s = a + b;
            OP_SUB:  y_s = a - b;
            OP_INC:  y_s = b + WORD_ONE;
            OP_DEC:  y_s = b - WORD_ONE;
            OP_SLT:  y_s = (a < b) ? WORD_ONE : {word_size{1'b0}};
            OP_SGT:  y_s = (a > b) ? WORD_ONE : {word_size{1'b0}};
            OP_AND:  y_s = a & b;
            OP_OR:   y_s = a | b;
            OP_NAND: y_s = ~(a & b);
            default: y_s = b;
        endcase
    end

    assign y = y_s;

endmodule

// File: rtl/processing_unit.sv
// processing_unit: datapath below the RISC control unit. Holds R0-R7, PC,
// PC_save, IR, Add_R, Reg_Y and Reg_Z and applies the control strobes each
// rising edge. Bus_1, Bus_2 and the ALU are combinational; every register
// load samples pre-edge values.
//   clk, rst                 clock, synchronous active-high reset
//   Load_R0..Load_R7         load Rn from Bus_2 (any combination at once)
//   Load_PC/Load_PC2/Inc_PC  PC update, in that priority order
//   Load_PC1                 PC_save <= pre-edge PC
//   Load_IR/Load_Add_R/Load_Reg_Y   load from Bus_2
//   Load_Reg_Z               Reg_Z <= (alu_out == 0)
//   Sel_Bus_1_Mux            0-7 R0-R7, 8 PC, others 0
//   Sel_Bus_2_Mux            0 ALU, 1 Bus_1, 2 mem_word, 3 zero
//   mem_word                 memory read data
//   instruction, zero        IR and Reg_Z back to the control unit
//   address, Bus_1           memory address (Add_R) and write data
module processing_unit
    import risc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Load_R0,
    input  logic                 Load_R1,
    input  logic                 Load_R2,
    input  logic                 Load_R3,
    input  logic                 Load_R4,
    input  logic                 Load_R5,
    input  logic                 Load_R6,
    input  logic                 Load_R7,
    input  logic                 Load_PC,
    input  logic                 Inc_PC,
    input  logic                 Load_PC1,
    input  logic                 Load_PC2,
    input  logic                 Load_IR,
    input  logic                 Load_Add_R,
    input  logic                 Load_Reg_Y,
    input  logic                 Load_Reg_Z,
    input  logic [Sel1_size-1:0] Sel_Bus_1_Mux,
    input  logic [Sel2_size-1:0] Sel_Bus_2_Mux,
    input  logic [word_size-1:0] mem_word,
    output logic [word_size-1:0] instruction,
    output logic                 zero,
    output logic [word_size-1:0] address,
    output logic [word_size-1:0] Bus_1
);

    logic [word_size-1:0] r_q [8];
    logic [word_size-1:0] r_d [8];
    logic [word_size-1:0] pc_q, pc_d;
    logic [word_size-1:0] pc_save_q, pc_save_d;
    logic [word_size-1:0] ir_q, ir_d;
    logic [word_size-1:0] add_r_q, add_r_d;
    logic [word_size-1:0] reg_y_q, reg_y_d;
    logic                 reg_z_q, reg_z_d;

    logic [7:0]           load_r_s;
    logic [word_size-1:0] bus_1_s;
    logic [word_size-1:0] bus_2_s;
    logic [word_size-1:0] alu_out_s;

    assign load_r_s = {Load_R7, Load_R6, Load_R5, Load_R4,
                       Load_R3, Load_R2, Load_R1, Load_R0};

    // Bus_1 source mux: codes 0-7 read the register file, 8 reads PC.
    always_comb begin
        bus_1_s = {word_size{1'b0}};
        if (Sel_Bus_1_Mux[3] == 1'b0) begin
            bus_1_s = r_q[Sel_Bus_1_Mux[2:0]];
        end else if (Sel_Bus_1_Mux == SEL1_PC) begin
            bus_1_s = pc_q;
        end else begin
            bus_1_s = {word_size{1'b0}};
        end
    end

    // Bus_2 source mux feeding every register load.
    always_comb begin
        bus_2_s = {word_size{1'b0}};
        case (Sel_Bus_2_Mux)
            SEL2_ALU:  bus_2_s = alu_out_s;
            SEL2_BUS1: bus_2_s = bus_1_s;
            SEL2_MEM:  bus_2_s = mem_word;
            SEL2_ZERO: bus_2_s = {word_size{1'b0}};
            default:   bus_2_s = {word_size{1'b0}};
        endcase
    end

    risc_alu u_alu (
        .a  (reg_y_q),
        .b  (bus_1_s),
        .op (ir_q[word_size-1 -: op_size]),
        .y  (alu_out_s)
    );

    // Next-state computation for all registers from the current strobes.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (load_r_s[i]) begin
                r_d[i] = bus_2_s;
            end else begin
                r_d[i] = r_q[i];
            end
        end

        // Load_PC wins over Load_PC2, which wins over Inc_PC.
        if (Load_PC) begin
            pc_d = bus_2_s;
        end else if (Load_PC2) begin
            pc_d = pc_save_q;
        end else if (Inc_PC) begin
            pc_d = pc_q + WORD_ONE;
        end else begin
            pc_d = pc_q;
        end

        // PC_save always captures the pre-edge PC, whatever PC does this cycle.
        if (Load_PC1) begin
            pc_save_d = pc_q;
        end else begin
            pc_save_d = pc_save_q;
        end

        if (Load_IR) begin
            ir_d = bus_2_s;
        end else begin
            ir_d = ir_q;
        end

        if (Load_Add_R) begin
            add_r_d = bus_2_s;
        end else begin
            add_r_d = add_r_q;
        end

        if (Load_Reg_Y) begin
            reg_y_d = bus_2_s;
        end else begin
            reg_y_d = reg_y_q;
        end

        if (Load_Reg_Z) begin
            reg_z_d = is_zero(alu_out_s);
        end else begin
            reg_z_d = reg_z_q;
        end
    end

    // State registers; reset overrides every strobe in its cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= {word_size{1'b0}};
            end
            pc_q      <= {word_size{1'b0}};
            pc_save_q <= {word_size{1'b0}};
            ir_q      <= {word_size{1'b0}};
            add_r_q   <= {word_size{1'b0}};
            reg_y_q   <= {word_size{1'b0}};
            reg_z_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= r_d[i];
            end
            pc_q      <= pc_d;
            pc_save_q <= pc_save_d;
            ir_q      <= ir_d;
            add_r_q   <= add_r_d;
            reg_y_q   <= reg_y_d;
            reg_z_q   <= reg_z_d;
        end
    end

    assign instruction = ir_q;
    assign zero        = reg_z_q;
    assign address     = add_r_q;
    assign Bus_1       = bus_1_s;

endmodule

// File: tb/tb_processing_unit.sv
// tb_processing_unit: directed, table-driven bench for processing_unit.
// Each table row is one clock cycle: strobes/selects/mem_word driven at the
// falling edge, Bus_1 compared before the rising edge, registered outputs
// compared 1 time unit after it. Reset sequences are hand-written tasks.
module tb_processing_unit;

    localparam logic [7:0] S_LPC  = 8'h80;
    localparam logic [7:0] S_INC  = 8'h40;
    localparam logic [7:0] S_PC1  = 8'h20;
    localparam logic [7:0] S_PC2  = 8'h10;
    localparam logic [7:0] S_IR   = 8'h08;
    localparam logic [7:0] S_AR   = 8'h04;
    localparam logic [7:0] S_Y    = 8'h02;
    localparam logic [7:0] S_Z    = 8'h01;

    localparam logic [3:0] C_B1 = 4'h8;
    localparam logic [3:0] C_IR = 4'h4;
    localparam logic [3:0] C_Z  = 4'h2;
    localparam logic [3:0] C_AD = 4'h1;

    typedef struct {
        string      name;
        logic [7:0] ld_r;
        logic [7:0] misc;
        logic [3:0] sel1;
        logic [1:0] sel2;
        logic [7:0] mem;
        logic [3:0] chk;
        logic [7:0] e_bus1;
        logic [7:0] e_ir;
        logic       e_z;
        logic [7:0] e_addr;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] ld_r;
    logic [7:0] misc;
    logic [3:0] sel1;
    logic [1:0] sel2;
    logic [7:0] mem;
    logic [7:0] instruction;
    logic       zero;
    logic [7:0] address;
    logic [7:0] bus_1;

    int total;
    int bad;
    vec_t tbl[$];

    processing_unit dut (
        .clk           (clk),
        .rst           (rst),
        .Load_R0       (ld_r[0]),
        .Load_R1       (ld_r[1]),
        .Load_R2       (ld_r[2]),
        .Load_R3       (ld_r[3]),
        .Load_R4       (ld_r[4]),
        .Load_R5       (ld_r[5]),
        .Load_R6       (ld_r[6]),
        .Load_R7       (ld_r[7]),
        .Load_PC       (misc[7]),
        .Inc_PC        (misc[6]),
        .Load_PC1      (misc[5]),
        .Load_PC2      (misc[4]),
        .Load_IR       (misc[3]),
        .Load_Add_R    (misc[2]),
        .Load_Reg_Y    (misc[1]),
        .Load_Reg_Z    (misc[0]),
        .Sel_Bus_1_Mux (sel1),
        .Sel_Bus_2_Mux (sel2),
        .mem_word      (mem),
        .instruction   (instruction),
        .zero          (zero),
        .address       (address),
        .Bus_1         (bus_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [7:0] l, input logic [7:0] m,
                       input logic [3:0] s1, input logic [1:0] s2, input logic [7:0] mw,
                       input logic [3:0] c, input logic [7:0] eb, input logic [7:0] ei,
                       input logic ez, input logic [7:0] ea);
        vec_t v;
        v.name = nm; v.ld_r = l; v.misc = m; v.sel1 = s1; v.sel2 = s2; v.mem = mw;
        v.chk = c; v.e_bus1 = eb; v.e_ir = ei; v.e_z = ez; v.e_addr = ea;
        tbl.push_back(v);
    endtask

    task automatic clear_inputs();
        ld_r = 8'h00; misc = 8'h00; sel1 = 4'h0; sel2 = 2'h0; mem = 8'h00;
    endtask

    task automatic random_inputs();
        ld_r = 8'($urandom); misc = 8'($urandom); sel1 = 4'($urandom);
        sel2 = 2'($urandom); mem = 8'($urandom);
    endtask

    // Random activity, two reset cycles with random strobes, then check all
    // state is zero and that PC counts from 0 after release.
    task automatic reset_seq(input string tag, input int n_pre);
        for (int i = 0; i < n_pre; i++) begin
            @(negedge clk); rst = 1'b0; random_inputs();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rst = 1'b1; random_inputs();
        end
        @(posedge clk); #1;
        check({tag, "_instr"}, instruction, 8'h00);
        check({tag, "_zero"}, {7'd0, zero}, 8'h00);
        check({tag, "_addr"}, address, 8'h00);
        @(negedge clk); rst = 1'b0; clear_inputs();
        for (int s = 0; s < 9; s++) begin
            sel1 = 4'(s); #1;
            check($sformatf("%s_bus1_sel%0d", tag, s), bus_1, 8'h00);
        end
        @(negedge clk); misc = S_INC;
        @(posedge clk); #1;
        @(negedge clk); misc = 8'h00; sel1 = 4'd8; #1;
        check({tag, "_inc_pc"}, bus_1, 8'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();

        //   name            ld_r   misc              s1    s2    mem    chk            bus1   ir     z     addr
        add("pc_ld05",       8'h00, S_LPC,            4'd0, 2'd2, 8'h05, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("fetch_addr",    8'h00, S_AR,             4'd8, 2'd1, 8'h00, C_B1|C_AD|C_Z, 8'h05, 8'h00, 1'b0, 8'h05);
        add("fetch_ir",      8'h00, S_IR|S_INC,       4'd0, 2'd2, 8'h1A, C_IR|C_AD,     8'h00, 8'h1A, 1'b0, 8'h05);
        add("pc_06",         8'h00, 8'h00,            4'd8, 2'd0, 8'h00, C_B1,          8'h06, 8'h00, 1'b0, 8'h00);
        add("r1_f0",         8'h02, 8'h00,            4'd0, 2'd2, 8'hF0, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("r2_20",         8'h04, 8'h00,            4'd0, 2'd2, 8'h20, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("ir_12",         8'h00, S_IR,             4'd0, 2'd2, 8'h12, C_IR,          8'h00, 8'h12, 1'b0, 8'h00);
        add("ry_r1",         8'h00, S_Y,              4'd1, 2'd1, 8'h00, C_B1,          8'hF0, 8'h00, 1'b0, 8'h00);
        add("add_r2",        8'h04, S_Z,              4'd2, 2'd0, 8'h00, C_B1|C_Z,      8'h20, 8'h00, 1'b0, 8'h00);
        add("r2_sum",        8'h00, 8'h00,            4'd2, 2'd0, 8'h00, C_B1,          8'h10, 8'h00, 1'b0, 8'h00);
        add("r3_44",         8'h08, 8'h00,            4'd0, 2'd2, 8'h44, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("ir_35",         8'h00, S_IR,             4'd0, 2'd2, 8'h35, C_IR,          8'h00, 8'h35, 1'b0, 8'h00);
        add("ry_r3",         8'h00, S_Y,              4'd3, 2'd1, 8'h00, C_B1,          8'h44, 8'h00, 1'b0, 8'h00);
        add("sub_zero",      8'h00, S_Z,              4'd3, 2'd3, 8'h00, C_Z,           8'h00, 8'h00, 1'b1, 8'h00);
        add("z_hold1",       8'h00, 8'h00,            4'd1, 2'd0, 8'h00, C_Z,           8'h00, 8'h00, 1'b1, 8'h00);
        add("z_hold2",       8'h00, 8'h00,            4'd1, 2'd0, 8'h00, C_Z,           8'h00, 8'h00, 1'b1, 8'h00);
        add("z_hold3",       8'h00, 8'h00,            4'd1, 2'd0, 8'h00, C_Z,           8'h00, 8'h00, 1'b1, 8'h00);
        add("pc_ff",         8'h00, S_LPC,            4'd0, 2'd2, 8'hFF, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("pc_ff_chk",     8'h00, 8'h00,            4'd8, 2'd0, 8'h00, C_B1,          8'hFF, 8'h00, 1'b0, 8'h00);
        add("pc_wrap",       8'h00, S_INC,            4'd0, 2'd0, 8'h00, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("pc_wrap_chk",   8'h00, 8'h00,            4'd8, 2'd0, 8'h00, C_B1,          8'h00, 8'h00, 1'b0, 8'h00);
        add("pc_prio",       8'h00, S_LPC|S_PC2|S_INC,4'd0, 2'd2, 8'h40, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("pc_prio_chk",   8'h00, 8'h00,            4'd8, 2'd0, 8'h00, C_B1,          8'h40, 8'h00, 1'b0, 8'h00);
        add("pc_save",       8'h00, S_PC1|S_INC,      4'd0, 2'd0, 8'h00, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("pc_41_chk",     8'h00, 8'h00,            4'd8, 2'd0, 8'h00, C_B1,          8'h41, 8'h00, 1'b0, 8'h00);
        add("pc_restore",    8'h00, S_PC2|S_INC,      4'd0, 2'd0, 8'h00, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("pc_rest_chk",   8'h00, 8'h00,            4'd8, 2'd0, 8'h00, C_B1,          8'h40, 8'h00, 1'b0, 8'h00);
        add("r4_07",         8'h10, 8'h00,            4'd0, 2'd2, 8'h07, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("hazard_old",    8'h10, 8'h00,            4'd4, 2'd2, 8'h09, C_B1,          8'h07, 8'h00, 1'b0, 8'h00);
        add("hazard_new",    8'h00, 8'h00,            4'd4, 2'd0, 8'h00, C_B1,          8'h09, 8'h00, 1'b0, 8'h00);
        add("sel1_12",       8'h00, 8'h00,            4'd12,2'd0, 8'h00, C_B1,          8'h00, 8'h00, 1'b0, 8'h00);
        add("sel1_9",        8'h00, 8'h00,            4'd9, 2'd0, 8'h00, C_B1,          8'h00, 8'h00, 1'b0, 8'h00);
        add("sel1_15",       8'h00, 8'h00,            4'd15,2'd0, 8'h00, C_B1,          8'h00, 8'h00, 1'b0, 8'h00);
        add("multi_ld",      8'hC0, 8'h00,            4'd0, 2'd2, 8'h5A, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("r6_chk",        8'h00, 8'h00,            4'd6, 2'd0, 8'h00, C_B1,          8'h5A, 8'h00, 1'b0, 8'h00);
        add("r7_chk",        8'h00, 8'h00,            4'd7, 2'd0, 8'h00, C_B1,          8'h5A, 8'h00, 1'b0, 8'h00);
        add("r0_33",         8'h01, 8'h00,            4'd0, 2'd2, 8'h33, 4'h0,          8'h00, 8'h00, 1'b0, 8'h00);
        add("r0_bus2_zero",  8'h01, 8'h00,            4'd0, 2'd3, 8'hEE, C_B1,          8'h33, 8'h00, 1'b0, 8'h00);
        add("r0_cleared",    8'h00, 8'h00,            4'd0, 2'd0, 8'h00, C_B1|C_AD,     8'h00, 8'h00, 1'b0, 8'h05);
        // ALU ops with Reg_Y = 44; result to R5, read back while loading next IR.
        add("ir_and",        8'h00, S_IR,             4'd5, 2'd2, 8'hB0, C_B1|C_IR,     8'h00, 8'hB0, 1'b0, 8'h00);
        add("and",           8'h20, S_Z,              4'd1, 2'd0, 8'h00, C_B1|C_Z,      8'hF0, 8'h00, 1'b0, 8'h00);
        add("ir_nand",       8'h00, S_IR,             4'd5, 2'd2, 8'hFF, C_B1|C_IR,     8'h40, 8'hFF, 1'b0, 8'h00);
        add("nand",          8'h20, S_Z,              4'd3, 2'd0, 8'h00, C_Z,           8'h00, 8'h00, 1'b0, 8'h00);
        add("ir_slt",        8'h00, S_IR,             4'd5, 2'd2, 8'h90, C_B1|C_IR,     8'hBB, 8'h90, 1'b0, 8'h00);
        add("slt",           8'h20, S_Z,              4'd1, 2'd0, 8'h00, C_Z,           8'h00, 8'h00, 1'b0, 8'h00);
        add("ir_sgt",        8'h00, S_IR,             4'd5, 2'd2, 8'hA0, C_B1|C_IR,     8'h01, 8'hA0, 1'b0, 8'h00);
        add("sgt",           8'h20, S_Z,              4'd1, 2'd0, 8'h00, C_Z,           8'h00, 8'h00, 1'b1, 8'h00);
        add("ir_or",         8'h00, S_IR,             4'd5, 2'd2, 8'hD0, C_B1|C_IR,     8'h00, 8'hD0, 1'b0, 8'h00);
        add("or",            8'h20, S_Z,              4'd2, 2'd0, 8'h00, C_Z,           8'h00, 8'h00, 1'b0, 8'h00);
        add("ir_inc",        8'h00, S_IR,             4'd5, 2'd2, 8'h40, C_B1|C_IR,     8'h54, 8'h40, 1'b0, 8'h00);
        add("inc",           8'h20, S_Z,              4'd7, 2'd0, 8'h00, C_Z,           8'h00, 8'h00, 1'b0, 8'h00);
        add("ir_dec",        8'h00, S_IR,             4'd5, 2'd2, 8'h50, C_B1|C_IR,     8'h5B, 8'h50, 1'b0, 8'h00);
        add("dec",           8'h20, S_Z,              4'd0, 2'd0, 8'h00, C_Z,           8'h00, 8'h00, 1'b0, 8'h00);
        add("ir_pass",       8'h00, S_IR,             4'd5, 2'd2, 8'h70, C_B1|C_IR,     8'hFF, 8'h70, 1'b0, 8'h00);
        add("pass",          8'h20, S_Z,              4'd4, 2'd0, 8'h00, C_Z,           8'h00, 8'h00, 1'b0, 8'h00);
        add("ir_sub",        8'h00, S_IR,             4'd5, 2'd2, 8'h30, C_B1|C_IR,     8'h09, 8'h30, 1'b0, 8'h00);
        add("sub",           8'h20, S_Z,              4'd1, 2'd0, 8'h00, C_Z,           8'h00, 8'h00, 1'b0, 8'h00);
        add("sub_chk",       8'h00, 8'h00,            4'd5, 2'd0, 8'h00, C_B1,          8'h54, 8'h00, 1'b0, 8'h00);

        @(negedge clk);
        reset_seq("rst_init", 3);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            ld_r = tbl[i].ld_r; misc = tbl[i].misc; sel1 = tbl[i].sel1;
            sel2 = tbl[i].sel2; mem = tbl[i].mem;
            #1;
            if (tbl[i].chk[3]) check($sformatf("%0d_%s_bus1", i, tbl[i].name), bus_1, tbl[i].e_bus1);
            @(posedge clk); #1;
            if (tbl[i].chk[2]) check($sformatf("%0d_%s_instr", i, tbl[i].name), instruction, tbl[i].e_ir);
            if (tbl[i].chk[1]) check($sformatf("%0d_%s_zero", i, tbl[i].name), {7'd0, zero}, {7'd0, tbl[i].e_z});
            if (tbl[i].chk[0]) check($sformatf("%0d_%s_addr", i, tbl[i].name), address, tbl[i].e_addr);
        end

        // Reset with state loaded from the table: nothing may survive.
        reset_seq("rst_mid", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
